// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multi-cycle signed divider: ALU opcode and FSM state encoding.
package seq_divider_pkg;

  localparam logic [4:0] ALU_OP_DIV = 5'b01111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational non-restoring division iteration on magnitudes.
// The partial remainder is WIDTH+1 bits signed.
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;

  // Bring in the next dividend bit.
  // Subtract while the remainder is non-negative, add back while it is negative.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    dvs_ext = {1'b0, dvs_i};
    if (rem_i[WIDTH]) begin
      rem_o = shifted + dvs_ext;
    end else begin
      rem_o = shifted - dvs_ext;
    end
    quo_o = {quo_i[WIDTH-2:0], ~rem_o[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: quotient truncates toward zero, remainder takes the dividend's sign.
// A zero divisor gives all-ones quotient, dividend as remainder, and raises div_by_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, dvs_q;
  logic             neg_dvd_q, neg_dvs_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_by_zero_q;

  logic             divisor_zero;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   rem_step, rem_fix;
  logic [WIDTH-1:0] quo_step, quo_final, rem_final;

  assign divisor_zero = (divisor_i == '0);
  assign abs_dvd      = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign abs_dvs      = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  // A negative final partial remainder needs one restoring add before the signs are applied.
  always_comb begin
    rem_fix   = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;
    quo_final = (neg_dvd_q ^ neg_dvs_q) ? -quo_q : quo_q;
    rem_final = neg_dvd_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start_i) state_d = divisor_zero ? DIV_FIX : DIV_CALC;
      DIV_CALC: if (count_q == CNT_LAST) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    done_o = (state_q == DIV_DONE);
  end

  // On a zero divisor the quotient register carries the raw dividend through to FIX.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      count_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_dvd_q     <= 1'b0;
      neg_dvs_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            neg_dvd_q <= dividend_i[WIDTH-1];
            neg_dvs_q <= divisor_i[WIDTH-1];
            dvs_q     <= abs_dvs;
            rem_q     <= '0;
            count_q   <= '0;
            dbz_q     <= divisor_zero;
            quo_q     <= divisor_zero ? dividend_i : abs_dvd;
          end
        end
        DIV_CALC: begin
          rem_q   <= rem_step;
          quo_q   <= quo_step;
          count_q <= count_q + CNT_ONE;
        end
        DIV_FIX: begin
          if (dbz_q) begin
            quotient_q    <= '1;
            remainder_q   <= quo_q;
            div_by_zero_q <= 1'b1;
          end else begin
            quotient_q    <= quo_final;
            remainder_q   <= rem_final;
            div_by_zero_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;

endmodule
